// File: rtl/cla.sv
// cla: 32-bit two-level carry-lookahead adder with carry/overflow flags and a registered copy.
module cla_grp (
  input  logic [3:0] g,
  input  logic [3:0] p,
  input  logic       ci,
  output logic [3:0] c,
  output logic       gg,
  output logic       pg
);
  always_comb begin
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    pg   = &p;
  end
endmodule

module cla #(
  parameter int DATA_WIDTH = 32
) (
  output logic [DATA_WIDTH-1:0] Z,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  clock,
  input  logic                  clear,
  output logic                  cout,
  output logic                  ovf,
  output logic [DATA_WIDTH-1:0] Z_q,
  output logic                  cout_q,
  output logic                  ovf_q
);
  localparam int NG = DATA_WIDTH / 4;
  logic [DATA_WIDTH-1:0] g, p, c;
  logic [NG-1:0] gg, pg;
  logic [NG:0] gc;
  logic [DATA_WIDTH-1:0] z_d;
  logic cout_d, ovf_d;
  assign g = A & B;
  assign p = A ^ B;
  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla_grp u_grp (
      .g (g[4*k +: 4]),
      .p (p[4*k +: 4]),
      .ci(gc[k]),
      .c (c[4*k +: 4]),
      .gg(gg[k]),
      .pg(pg[k])
    );
  end
  // each group carry is an independent OR of AND terms; nothing chains between groups
  always_comb begin
    logic t;
    gc = '0;
    for (int j = 1; j <= NG; j++) begin
      t = 1'b0;
      for (int k = 0; k < j; k++) t &= pg[k];
      gc[j] = t;
      for (int i = 0; i < j; i++) begin
        t = gg[i];
        for (int k = i + 1; k < j; k++) t &= pg[k];
        gc[j] |= t;
      end
    end
  end
  assign Z    = p ^ c;
  assign cout = gc[NG];
  assign ovf  = (A[DATA_WIDTH-1] == B[DATA_WIDTH-1]) && (Z[DATA_WIDTH-1] != A[DATA_WIDTH-1]);
  always_comb begin
    z_d    = Z;
    cout_d = cout;
    ovf_d  = ovf;
  end
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      Z_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      Z_q    <= z_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end
endmodule

// File: tb/tb_cla.sv
// tb_cla: directed and random checks of cla against an arithmetic reference model.
module tb_cla;
  logic [31:0] Z, A, B, Z_q;
  logic clock = 1'b0, clear = 1'b0;
  logic cout, ovf, cout_q, ovf_q;
  int checks = 0, errors = 0;

  cla dut (
    .Z(Z), .A(A), .B(B), .clock(clock), .clear(clear),
    .cout(cout), .ovf(ovf), .Z_q(Z_q), .cout_q(cout_q), .ovf_q(ovf_q)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // {cout, ovf, sum}: cout from 33-bit unsigned add, ovf from wide signed range
  function automatic logic [33:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] u;
    longint s, lim;
    u   = {1'b0, a} + {1'b0, b};
    s   = longint'($signed(a)) + longint'($signed(b));
    lim = 64'sd1 <<< 31;
    return {u[32], (s >= lim) || (s < -lim), u[31:0]};
  endfunction

  task automatic drive_chk(input string tag, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    A = a;
    B = b;
    #1 chk(tag, {30'd0, cout, ovf, Z}, {30'd0, ref_add(a, b)});
  endtask

  initial begin
    logic [31:0] ta, tb;
    A = 0;
    B = 0;
    #2 chk("reset_regs", {30'd0, cout_q, ovf_q, Z_q}, 64'd0);
    drive_chk("zero", 32'd0, 32'd0);
    chk("zero_exact", {30'd0, cout, ovf, Z}, 64'd0);
    drive_chk("7p22", 32'd7, 32'd22);
    chk("7p22_exact", {32'd0, Z}, 64'd29);
    drive_chk("100p50", 32'd100, 32'd50);
    chk("100p50_exact", {32'd0, Z}, 64'd150);
    drive_chk("allones_p1", 32'hFFFF_FFFF, 32'd1);
    chk("allones_exact", {30'd0, cout, ovf, Z}, {30'd0, 2'b10, 32'd0});
    drive_chk("100m50", 32'd100, 32'hFFFF_FFCE);
    chk("100m50_exact", {30'd0, cout, ovf, Z}, {30'd0, 2'b10, 32'd50});
    drive_chk("100m150", 32'd100, 32'hFFFF_FF6A);
    chk("100m150_exact", {30'd0, cout, ovf, Z}, {30'd0, 2'b00, 32'hFFFF_FFCE});
    drive_chk("sovf", 32'h7FFF_FFFF, 32'd1);
    chk("sovf_exact", {30'd0, cout, ovf, Z}, {30'd0, 2'b01, 32'h8000_0000});
    drive_chk("novf", 32'h8000_0000, 32'h8000_0000);
    chk("novf_exact", {30'd0, cout, ovf, Z}, {30'd0, 2'b11, 32'd0});
    drive_chk("held_clear", 32'd7, 32'd22);
    repeat (3) @(posedge clock);
    #1 chk("zq_in_clear", {30'd0, cout_q, ovf_q, Z_q}, 64'd0);
    chk("z_in_clear", {32'd0, Z}, 64'd29);
    @(negedge clock) clear = 1'b1;
    #1 chk("zq_before_edge", {32'd0, Z_q}, 64'd0);
    @(posedge clock);
    #1 chk("zq_after_release", {32'd0, Z_q}, 64'd29);
    #2 clear = 1'b0;
    #1 chk("zq_async_clear", {30'd0, cout_q, ovf_q, Z_q}, 64'd0);
    chk("z_tracks_in_clear", {32'd0, Z}, 64'd29);
    @(negedge clock) clear = 1'b1;
    drive_chk("reg_sovf", 32'h7FFF_FFFF, 32'd1);
    @(posedge clock);
    #1 chk("reg_sovf_q", {30'd0, cout_q, ovf_q, Z_q}, {30'd0, 2'b01, 32'h8000_0000});
    for (int i = 0; i < 400; i++) begin
      ta = $urandom;
      tb = $urandom;
      case (i % 8)
        1: tb = ~ta + 32'd1;
        2: tb = ~ta;
        3: begin ta[31] = 1'b0; tb[31] = 1'b0; ta[30] = 1'b1; end
        4: begin ta[31] = 1'b1; tb[31] = 1'b1; end
        default: ;
      endcase
      drive_chk("rand_comb", ta, tb);
      @(posedge clock);
      #1 chk("rand_reg", {30'd0, cout_q, ovf_q, Z_q}, {30'd0, ref_add(ta, tb)});
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
